// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
// Divides the I2S PLL clock into MCLK, BCLK and LRCK and shifts out 24-bit
// stereo samples in Philips I2S format. A frame is 64 BCLK long and holds two
// 32-bit slots, each sample MSB-first and zero-padded. A new stereo pair is
// taken over a one-cycle s_ready strobe at every frame boundary. A missing
// pair sends a silent frame and bumps a saturating underrun counter.

module i2s_tx_serializer #(
  parameter int BCLK_HALF = 16,
  parameter int MCLK_HALF = 2,
  parameter int SAMPLE_W  = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [SAMPLE_W-1:0] s_left,
  input  logic signed [SAMPLE_W-1:0] s_right,
  output logic                       i2s_mclk,
  output logic                       i2s_bclk,
  output logic                       i2s_lrck,
  output logic                       i2s_sdata,
  output logic [15:0]                underrun_cnt
);

  // A counter needs at least one bit even when it only ever holds 0.
  localparam int MC_W  = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(MCLK_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [5:0]       BIT_LAST = 6'd63;

  // Saturating increment for the underrun counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Left-justify a sample inside a 32-bit slot; the unused low bits are zero.
  function automatic logic [31:0] slot_word(input logic signed [SAMPLE_W-1:0] smp);
    logic [31:0] ext;
    ext = 32'(smp);
    return ext << (32 - SAMPLE_W);
  endfunction

  logic [MC_W-1:0]  mclk_cnt_q, mclk_cnt_d;
  logic             mclk_q, mclk_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             lrck_q, lrck_d;
  logic             sdata_q, sdata_d;
  logic [63:0]      sreg_q, sreg_d;
  logic             s_ready_q, s_ready_d;
  logic [15:0]      underrun_q, underrun_d;

  logic             div_wrap;
  logic             fall_evt;
  logic             frame_load;
  logic [63:0]      frame_word;

  // MCLK divider: free-running whenever out of reset, regardless of en.
  always_comb begin
    mclk_cnt_d = mclk_cnt_q + MC_W'(1);
    mclk_d     = mclk_q;
    if (mclk_cnt_q == MC_LAST) begin
      mclk_cnt_d = '0;
      mclk_d     = ~mclk_q;
    end
  end

  // BCLK divider and the event decode that drives the frame logic.
  always_comb begin
    div_wrap   = (div_cnt_q == DIV_LAST);
    fall_evt   = en && div_wrap && bclk_q;
    frame_load = fall_evt && (bit_cnt_q == BIT_LAST);
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    if (!en) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (div_wrap) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Frame sequencer: slot counter, word select, shifter, load handshake.
  always_comb begin
    frame_word = {slot_word(s_left), slot_word(s_right)};
    bit_cnt_d  = bit_cnt_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    sreg_d     = sreg_q;
    s_ready_d  = 1'b0;
    underrun_d = underrun_q;
    if (!en) begin
      // Disabled: park the frame so re-enable starts a clean frame.
      bit_cnt_d = BIT_LAST;
      lrck_d    = 1'b0;
      sdata_d   = 1'b0;
      sreg_d    = '0;
    end else if (fall_evt) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrck_d    = bit_cnt_d[5];
      // The old MSB leaves on this fall; at a load it is the final padding
      // bit of the previous right slot, which delays the new left MSB by one
      // BCLK behind the LRCK edge.
      sdata_d   = sreg_q[63];
      if (frame_load) begin
        s_ready_d = 1'b1;
        if (s_valid) begin
          sreg_d = frame_word;
        end else begin
          sreg_d     = '0;
          underrun_d = sat_inc(underrun_q);
        end
      end else begin
        sreg_d = {sreg_q[62:0], 1'b0};
      end
    end
  end

  // State registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_cnt_q <= '0;
      mclk_q     <= 1'b0;
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= BIT_LAST;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      sreg_q     <= '0;
      s_ready_q  <= 1'b0;
      underrun_q <= '0;
    end else begin
      mclk_cnt_q <= mclk_cnt_d;
      mclk_q     <= mclk_d;
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      sreg_q     <= sreg_d;
      s_ready_q  <= s_ready_d;
      underrun_q <= underrun_d;
    end
  end

  assign i2s_mclk     = mclk_q;
  assign i2s_bclk     = bclk_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_sdata    = sdata_q;
  assign s_ready      = s_ready_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: a cycle-count based model of the I2S stream
// is compared against the default-parameter instance every cycle, alongside
// directed timing checks and a fast-clock instance (BCLK_HALF=2, MCLK_HALF=1).

module tb_i2s_tx_serializer;

  localparam int BH = 16;
  localparam int MH = 2;
  localparam int SW = 24;
  localparam int FR = 128 * BH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, en, s_valid, s_ready;
  logic signed [SW-1:0] s_left, s_right;
  logic                 i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdata;
  logic [15:0]          underrun_cnt;

  logic                 rst2, en2, s_valid2, s_ready2;
  logic signed [SW-1:0] s_left2, s_right2;
  logic                 mclk2, bclk2, lrck2, sdata2;
  logic [15:0]          uc2;

  i2s_tx_serializer #(.BCLK_HALF(BH), .MCLK_HALF(MH), .SAMPLE_W(SW)) dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .i2s_mclk(i2s_mclk),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
    .underrun_cnt(underrun_cnt));

  i2s_tx_serializer #(.BCLK_HALF(2), .MCLK_HALF(1), .SAMPLE_W(SW)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_left(s_left2), .s_right(s_right2), .i2s_mclk(mclk2),
    .i2s_bclk(bclk2), .i2s_lrck(lrck2), .i2s_sdata(sdata2),
    .underrun_cnt(uc2));

  int nchk = 0;
  int npass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Behavioural model: everything follows from the number of enabled cycles
  // since the stream (re)started and the words captured at each frame load.
  int          t, mt;
  logic [63:0] wcur, wprev;
  logic [15:0] muc;
  logic        ld;

  function automatic bit is_load(input int n);
    return (n > 0) && (n % (2 * BH) == 0) && (((n / (2 * BH)) - 1) % 64 == 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mt <= 0; t <= 0; muc <= 16'd0; wcur <= '0; wprev <= '0; ld <= 1'b0;
    end else begin
      mt <= mt + 1;
      if (!en) begin
        t <= 0; wcur <= '0; wprev <= '0; ld <= 1'b0;
      end else begin
        t  <= t + 1;
        ld <= is_load(t + 1);
        if (is_load(t + 1)) begin
          wprev <= wcur;
          wcur  <= s_valid ? {s_left, 8'h00, s_right, 8'h00} : 64'h0;
          if (!s_valid && muc != 16'hFFFF) muc <= muc + 16'd1;
        end
      end
    end
  end

  int   f, s;
  logic e_m, e_b, e_l, e_d;

  // Per-cycle compare of the default instance against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      f   = t / (2 * BH);
      e_b = ((t / BH) % 2) == 1;
      e_m = ((mt / MH) % 2) == 1;
      if (f == 0) begin
        e_l = 1'b0;
        e_d = 1'b0;
      end else begin
        s   = (f - 1) % 64;
        e_l = (s >= 32);
        e_d = (s == 0) ? wprev[0] : wcur[64 - s];
      end
      chk("cycle_outputs", {59'b0, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdata, s_ready},
          {59'b0, e_m, e_b, e_l, e_d, ld});
      chk("cycle_underrun", 64'(underrun_cnt), 64'(muc));
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0: return i2s_mclk;
      1: return i2s_bclk;
      2: return i2s_lrck;
      3: return s_ready;
      4: return bclk2;
      5: return s_ready2;
      default: return mclk2;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles until the selected signal reads 1; -1 if the budget runs out.
  task automatic wait_hi(input int w, input int maxc, output int n);
    n = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (sig(w)) begin
        n = k;
        break;
      end
    end
  endtask

  // Cycles between two successive rising edges of the selected signal.
  task automatic period_of(input int w, input int maxc, output int p);
    logic prev;
    bit   found;
    p = -1;
    found = 1'b0;
    prev = sig(w);
    for (int k = 0; k < maxc && !found; k++) begin
      @(negedge clk);
      if (!prev && sig(w)) found = 1'b1;
      prev = sig(w);
    end
    if (found) begin
      found = 1'b0;
      for (int k = 1; k <= maxc && !found; k++) begin
        @(negedge clk);
        if (!prev && sig(w)) begin
          found = 1'b1;
          p = k;
        end
        prev = sig(w);
      end
    end
  endtask

  // Wait for nf BCLK falling edges of the default instance.
  task automatic wait_falls(input int nf, output bit ok);
    logic prev;
    int   cnt;
    cnt = 0;
    prev = i2s_bclk;
    for (int k = 0; k < nf * 2 * BH + 4 && cnt < nf; k++) begin
      @(negedge clk);
      if (prev && !i2s_bclk) cnt++;
      prev = i2s_bclk;
    end
    ok = (cnt == nf);
  endtask

  initial begin
    int          n;
    bit          ok;
    logic [31:0] r;
    logic [63:0] pat, lrp, exp_pat, exp_lrp;
    logic        prev, quiet;
    int          tog, uc_before;

    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    rst2 = 1'b1; en2 = 1'b0; s_valid2 = 1'b1;
    s_left2 = 24'sh800001; s_right2 = 24'sh000001;
    cyc(3);
    chk_on = 1'b1;
    chk("reset_outputs", {59'b0, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdata, s_ready}, 64'h0);
    chk("reset_underrun", 64'(underrun_cnt), 64'h0);

    // Steady stream of a fixed pattern.
    s_left = 24'shA5A5A5; s_right = 24'sh5A5A5A; s_valid = 1'b1;
    rst = 1'b0; en = 1'b1;
    wait_hi(3, 100, n);
    chk("first_ready_latency", 64'(n), 64'd32);
    chk("model_word_pin", wcur, {24'hA5A5A5, 8'h00, 24'h5A5A5A, 8'h00});
    pat = '0; lrp = '0;
    for (int i = 0; i < 64; i++) begin
      prev = i2s_bclk;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (!prev && i2s_bclk) break;
        prev = i2s_bclk;
      end
      pat[63 - i] = i2s_sdata;
      lrp[63 - i] = i2s_lrck;
    end
    exp_pat = {1'b0, 24'hA5A5A5, 8'h00, 24'h5A5A5A, 7'h00};
    exp_lrp = {32'h0, 32'hFFFF_FFFF};
    chk("slot_data_pattern", pat, exp_pat);
    chk("slot_lrck_pattern", lrp, exp_lrp);
    period_of(1, 100, n);
    chk("bclk_period", 64'(n), 64'd32);
    period_of(0, 20, n);
    chk("mclk_period", 64'(n), 64'd4);
    wait_hi(3, FR + 8, n);
    cyc(1);
    chk("ready_width", 64'(s_ready), 64'd0);
    wait_hi(3, FR + 8, n);
    chk("ready_interval", 64'(n), 64'(FR - 1));
    period_of(2, 2 * FR + 8, n);
    chk("lrck_period", 64'(n), 64'(FR));

    // Three starved frames, then resume.
    wait_hi(3, FR + 8, n);
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_hi(3, FR + 8, n);
      chk("underrun_frame_interval", 64'(n), 64'(FR));
    end
    chk("underrun_count_3", 64'(underrun_cnt), 64'd3);
    s_valid = 1'b1;
    wait_hi(3, FR + 8, n);
    wait_hi(3, FR + 8, n);
    chk("underrun_hold_3", 64'(underrun_cnt), 64'd3);

    // Valid raised in the load cycle itself still transfers.
    s_valid = 1'b0;
    s_left = 24'sh123456; s_right = 24'sh654321;
    uc_before = int'(underrun_cnt);
    cyc(FR - 1);
    s_valid = 1'b1;
    wait_hi(3, 4, n);
    chk("late_valid_load", 64'(n), 64'd1);
    chk("late_valid_no_underrun", 64'(underrun_cnt), 64'(uc_before));

    // Randomised samples and gaps.
    for (int i = 0; i < 6; i++) begin
      r = $urandom; s_left = r[SW-1:0];
      r = $urandom; s_right = r[SW-1:0];
      s_valid = ($urandom_range(0, 3) != 0);
      wait_hi(3, FR + 8, n);
      chk("rand_frame_interval", 64'(n), 64'(FR));
    end

    // Reset in the middle of the right slot.
    s_valid = 1'b1; s_left = 24'shA5A5A5; s_right = 24'sh5A5A5A;
    wait_hi(3, FR + 8, n);
    wait_falls(40, ok);
    chk("reach_bit40", 64'(ok), 64'd1);
    rst = 1'b1;
    cyc(1);
    chk("midframe_rst_outputs", {59'b0, i2s_mclk, i2s_bclk, i2s_lrck, i2s_sdata, s_ready}, 64'h0);
    chk("midframe_rst_underrun", 64'(underrun_cnt), 64'h0);
    rst = 1'b0;
    wait_hi(3, 100, n);
    chk("post_rst_ready_latency", 64'(n), 64'd32);
    cyc(31);
    chk("post_rst_slot0", 64'(i2s_sdata), 64'd0);
    cyc(1);
    chk("post_rst_left_msb", 64'(i2s_sdata), 64'd1);

    // Enable dropped at bit 10 for 100 cycles.
    wait_hi(3, FR + 8, n);
    wait_falls(10, ok);
    chk("reach_bit10", 64'(ok), 64'd1);
    en = 1'b0;
    quiet = 1'b0; tog = 0; prev = i2s_mclk;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      quiet = quiet | i2s_bclk | i2s_lrck | i2s_sdata | s_ready;
      if (i2s_mclk != prev) tog++;
      prev = i2s_mclk;
    end
    chk("en_gap_quiet", 64'(quiet), 64'd0);
    chk("en_gap_mclk_toggles", 64'(tog), 64'd50);
    en = 1'b1;
    wait_hi(3, 100, n);
    chk("reenable_ready_latency", 64'(n), 64'd32);

    // Fast-clock instance.
    rst2 = 1'b0; en2 = 1'b1;
    wait_hi(5, 20, n);
    chk("fast_ready_latency", 64'(n), 64'd4);
    cyc(3);
    chk("fast_slot0", 64'(sdata2), 64'd0);
    cyc(1);
    chk("fast_left_msb", 64'(sdata2), 64'd1);
    wait_hi(5, 300, n);
    chk("fast_frame_interval", 64'(n), 64'd252);
    period_of(4, 20, n);
    chk("fast_bclk_period", 64'(n), 64'd4);
    period_of(6, 20, n);
    chk("fast_mclk_period", 64'(n), 64'd2);
    chk("fast_underrun", 64'(uc2), 64'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", npass, nchk);
    $fatal(1, "watchdog");
  end

endmodule
